// File: rtl/sample_tick_pkg.sv
// rtl/sample_tick_pkg.sv - shared types and helpers for the sample tick generator
// Purpose: lock FSM state type, default field width, divide/phase helper functions.
// Ports: none (package).
package sample_tick_pkg;

    typedef enum logic {
        LOCK_WAIT = 1'b0,
        RUN       = 1'b1
    } state_e;

    localparam int DEFAULT_DIV_W = 16;

    // Helpers work on a fixed 32-bit width; callers size-cast in and out so
    // any DIV_W up to 32 uses the same code.
    localparam int FN_W = 32;

    // A divide ratio of 0 has no meaning; it behaves as 1 (tick every cycle).
    function automatic logic [FN_W-1:0] norm_div(input logic [FN_W-1:0] div);
        return (div == '0) ? 32'd1 : div;
    endfunction

    // Preload value for a sync: the counter must never exceed div-1.
    function automatic logic [FN_W-1:0] clamp_phase(input logic [FN_W-1:0] phase,
                                                    input logic [FN_W-1:0] div);
        return (phase > (div - 32'd1)) ? (div - 32'd1) : phase;
    endfunction

endpackage

// File: rtl/sample_tick_chan.sv
// rtl/sample_tick_chan.sv - one programmable tick channel
// Purpose: divide counter with shadowed div/phase reconfiguration applied glitch-free.
// Ports:
//   clk, rst          clock, async active-high reset
//   run               lock FSM is in RUN; counter held at 0 otherwise
//   en                channel run enable
//   sync              realign counter to phase (applies any pending shadow first)
//   wr_stb            accepted config write for this channel
//   wr_div, wr_phase  new divide ratio (0 means 1) and phase
//   pending           shadow holds an unapplied write
//   tick              one-cycle enable pulse, high while count==0 after a wrap
//   tick_toggle       flips on every tick
module sample_tick_chan
    import sample_tick_pkg::*;
#(
    parameter int DIV_W       = DEFAULT_DIV_W,
    parameter int DEFAULT_DIV = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_stb,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_phase,
    output logic             pending,
    output logic             tick,
    output logic             tick_toggle
);

    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] shadow_div_q, shadow_div_d;
    logic [DIV_W-1:0] shadow_phase_q, shadow_phase_d;
    logic             pending_q, pending_d;
    logic             tick_q, tick_d;
    logic             toggle_q, toggle_d;
    logic             wrap;

    assign wrap = (count_q == (div_q - DIV_W'(1)));

    always_comb begin
        count_d        = count_q;
        div_d          = div_q;
        phase_d        = phase_q;
        shadow_div_d   = shadow_div_q;
        shadow_phase_d = shadow_phase_q;
        pending_d      = pending_q;
        tick_d         = 1'b0;
        toggle_d       = toggle_q;

        if (!run) begin
            count_d = '0;
        end else begin
            if (sync) begin
                if (pending_q) begin
                    div_d     = shadow_div_q;
                    phase_d   = shadow_phase_q;
                    pending_d = 1'b0;
                end
                // Preload uses the post-apply div/phase; sync beats a wrap, so no tick.
                count_d = DIV_W'(clamp_phase(FN_W'(phase_d), FN_W'(div_d)));
            end else if (en) begin
                if (wrap) begin
                    count_d  = '0;
                    tick_d   = 1'b1;
                    toggle_d = ~toggle_q;
                    // Reconfiguration lands exactly on a period boundary.
                    if (pending_q) begin
                        div_d     = shadow_div_q;
                        phase_d   = shadow_phase_q;
                        pending_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + DIV_W'(1);
                end
            end else if (pending_q) begin
                // A stopped channel has no boundary to wait for.
                div_d     = shadow_div_q;
                phase_d   = shadow_phase_q;
                pending_d = 1'b0;
                count_d   = '0;
            end

            // Never coincides with an apply: the top only strobes when not pending.
            if (wr_stb) begin
                shadow_div_d   = DIV_W'(norm_div(FN_W'(wr_div)));
                shadow_phase_d = wr_phase;
                pending_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q        <= '0;
            div_q          <= DIV_W'(DEFAULT_DIV);
            phase_q        <= '0;
            shadow_div_q   <= DIV_W'(DEFAULT_DIV);
            shadow_phase_q <= '0;
            pending_q      <= 1'b0;
            tick_q         <= 1'b0;
            toggle_q       <= 1'b0;
        end else begin
            count_q        <= count_d;
            div_q          <= div_d;
            phase_q        <= phase_d;
            shadow_div_q   <= shadow_div_d;
            shadow_phase_q <= shadow_phase_d;
            pending_q      <= pending_d;
            tick_q         <= tick_d;
            toggle_q       <= toggle_d;
        end
    end

    assign pending     = pending_q;
    assign tick        = tick_q;
    assign tick_toggle = toggle_q;

endmodule

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - multi-channel runtime-programmable clock-enable generator
// Purpose: lock wait after reset, config write routing, N tick channels, lock indication.
// Ports:
//   clk, rst                      clock, async active-high reset
//   cfg_valid/cfg_ready           config write handshake
//   cfg_ch, cfg_div, cfg_phase    target channel (out-of-range discarded), ratio, phase
//   en                            per-channel run enable
//   sync_pulse                    realign all channels to their phase
//   tick, tick_toggle             per-channel tick pulse and square wave
//   locked                        running with no pending reconfiguration (registered)
module sample_tick_gen
    import sample_tick_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = DEFAULT_DIV_W,
    parameter int DEFAULT_DIV = 9,
    parameter int LOCK_CYCLES = 64,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [DIV_W-1:0]    cfg_phase,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync_pulse,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] tick_toggle,
    output logic                locked
);

    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic                locked_q, locked_d;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] wr_stb;
    logic                sel_pending;
    logic                run;

    assign run = (state_q == RUN);

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (state_q == LOCK_WAIT) begin
            if (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) begin
                state_d = RUN;
            end else begin
                lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            end
        end
        locked_d = run & ~|pending;
    end

    // Out-of-range channels have no pending flag, so they are accepted and dropped.
    always_comb begin
        sel_pending = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                sel_pending = pending[i];
            end
        end
    end

    assign cfg_ready = run & ~sel_pending;

    always_comb begin
        wr_stb = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr_stb[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOCK_WAIT;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign locked = locked_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        sample_tick_chan #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .run         (run),
            .en          (en[g]),
            .sync        (sync_pulse),
            .wr_stb      (wr_stb[g]),
            .wr_div      (cfg_div),
            .wr_phase    (cfg_phase),
            .pending     (pending[g]),
            .tick        (tick[g]),
            .tick_toggle (tick_toggle[g])
        );
    end

endmodule
